spi_txn_scheduler: RTL
======================

Name: spi_txn_scheduler

Overview:
- Round-robin scheduler that shares one SPI serializer between NREQ on-chip requesters.
- Sequences each transaction end to end:
  - latches the winning {opcode, addr};
  - drives the serializer's chip-select and valid handshake;
  - waits for shift-out completion;
  - returns a per-requester done/error pulse.
- Sits between the request queue and the serializer; clk is the fast system clock.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ADDRW, 8, address width, matches serializer.
- OPCODEW, 2, opcode width, matches serializer.
- CS_SETUP, 16, clk cycles n_cs is held low before valid is raised (covers serializer n_cs sync/debounce).
- CS_HOLD, 16, clk cycles n_cs stays low after completion.
- TIMEOUT, 4096, max clk cycles in ISSUE+BUSY before abort.
- MAX_RETRY, 2, retry limit (only with SER_RETRY_EN).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request level; held until gnt.
- req_opcode  in  NREQ*OPCODEW  packed opcodes; requester i at [i*OPCODEW +: OPCODEW].
- req_addr  in  NREQ*ADDRW  packed addresses; same packing.
- gnt  out  NREQ  one-hot, 1-cycle pulse: payload latched, requester may drop req.
- done  out  NREQ  one-hot, 1-cycle pulse: transaction finished.
- done_err  out  1  qualifies done: 1 = transaction failed.
- busy  out  1  high in any state other than IDLE.
- ser_valid  out  1  valid to serializer.
- ser_opcode  out  OPCODEW  latched opcode.
- ser_addr  out  ADDRW  latched address.
- ser_n_cs  out  1  chip select to serializer, active low.
- ser_ready  in  1  serializer ready (high = idle).
- ser_err  in  1  serializer abort flag.

Behaviour:
- Reset (async, rst_n low), all registers registered:
  - gnt=0, done=0, done_err=0, busy=0, ser_valid=0, ser_n_cs=1, ser_opcode=0, ser_addr=0.
  - RR pointer=NREQ-1, so requester 0 has first priority.
  - State IDLE; counters 0.
- Reset mid-transaction aborts immediately; no done pulse is emitted.
- IDLE:
  - If any req bit is set, pick the first set bit searching from ptr+1 with modulo NREQ wrap.
  - Latch that requester's opcode/addr into ser_opcode/ser_addr, pulse gnt[i] for one cycle, set ptr=i, go to SETUP.
  - Grant is issued in the cycle after req is seen.
- SETUP: ser_n_cs=0; count CS_SETUP cycles, then go to ISSUE.
- ISSUE:
  - ser_valid=1.
  - On ser_ready==0 (serializer accepted): ser_valid=0, go to BUSY.
- BUSY:
  - On ser_ready==1: go to HOLD with status ok.
  - ser_err==1 in any of SETUP/ISSUE/BUSY: ser_valid=0, go to HOLD with status err.
- Timeout:
  - Counter is cleared on entry to ISSUE and counts through ISSUE+BUSY.
  - On reaching TIMEOUT-1: ser_valid=0, go to HOLD with status err.
- HOLD: ser_n_cs stays 0 for CS_HOLD cycles, then ser_n_cs=1 and go to RESP.
- RESP:
  - Pulse done[i] for one cycle, with done_err=status; go to IDLE.
  - ser_n_cs is high for at least 1 cycle between transactions.
- ser_n_cs never rises while ser_ready==0 except through timeout.
- Simultaneous ser_err and ser_ready rise: err wins.
- req dropped before gnt is legal (request withdrawn); req asserted during busy waits.
- Fairness: each requester is granted at most once per NREQ grants while others are pending.
- Minimum transaction latency, req to done: 1 + CS_SETUP + (serializer latency) + CS_HOLD + 1 cycles.

Optional Feature:
- Macro SER_RETRY_EN.
- Defined: on error (ser_err or timeout), if retry count < MAX_RETRY:
  - go HOLD → SETUP, re-issue the same latched payload, increment retry count;
  - no done and no new arbitration in between;
  - done_err=1 only after MAX_RETRY+1 failed attempts;
  - retry count is cleared at each gnt.
- Not defined: a single attempt; any error goes straight to done with done_err=1.

Test Plan:
- Single request: req[2]=1, opcode=2'b10, addr=8'hA5; model accepts and completes → gnt[2] one pulse, ser_opcode=2'b10, ser_addr=8'hA5, ser_n_cs low ≥16 cycles before ser_valid, done[2]=1, done_err=0.
- All four requesters held continuously → grant order 0,1,2,3,0; no requester granted twice in any 4 consecutive grants.
- Serializer model raises ser_err mid-BUSY → ser_valid=0, ser_n_cs high after 16 cycles; done pulse with done_err=1 (retry off), or 3 attempts then done_err=1 (SER_RETRY_EN, MAX_RETRY=2).
- Serializer never drops ser_ready → after 4096 cycles: done_err=1, ser_n_cs=1, busy=0 one cycle later.
- rst_n asserted low during BUSY → same cycle (async): ser_n_cs=1, ser_valid=0, busy=0; no done pulse; next grant goes to requester 0.
- req[1] pulsed for one cycle and dropped while scheduler is busy with requester 0 → no gnt[1] and no done[1].

Source files
------------

// File: rtl/spi_txn_scheduler.sv
// spi_txn_scheduler
//   Round-robin scheduler that shares one SPI serializer between NREQ
//   requesters. It wins one request, latches its {opcode, addr}, frames the
//   transfer with chip-select setup/hold time, hands it to the serializer,
//   waits for the shift-out to finish (or fail / time out) and then reports
//   a per-requester done pulse qualified by done_err.
//
//   Optional build macro: SER_RETRY_EN
//     When defined, a failed attempt is re-issued from SETUP with the same
//     latched payload up to MAX_RETRY times before done_err is reported.
//     When undefined, every failure is reported on the first attempt.
//
// Ports
//   clk, rst_n             system clock, asynchronous active-low reset
//   req                    per-requester request level, held until gnt
//   req_opcode, req_addr   packed payloads, requester i at [i*W +: W]
//   gnt                    one-hot 1-cycle pulse, payload has been latched
//   done, done_err         one-hot 1-cycle completion pulse, 1 = failed
//   busy                   high whenever a transaction is in flight
//   ser_valid              request valid towards the serializer
//   ser_opcode, ser_addr   latched payload towards the serializer
//   ser_n_cs               active-low chip select towards the serializer
//   ser_ready, ser_err     serializer idle flag and abort flag

module spi_txn_scheduler #(
  parameter int NREQ      = 4,
  parameter int ADDRW     = 8,
  parameter int OPCODEW   = 2,
  parameter int CS_SETUP  = 16,
  parameter int CS_HOLD   = 16,
  parameter int TIMEOUT   = 4096,
  parameter int MAX_RETRY = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*OPCODEW-1:0] req_opcode,
  input  logic [NREQ*ADDRW-1:0]   req_addr,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic                    done_err,
  output logic                    busy,
  output logic                    ser_valid,
  output logic [OPCODEW-1:0]      ser_opcode,
  output logic [ADDRW-1:0]        ser_addr,
  output logic                    ser_n_cs,
  input  logic                    ser_ready,
  input  logic                    ser_err
);

  localparam int IDXW    = $clog2(NREQ);
  localparam int CNT_MAX = (TIMEOUT > CS_SETUP) ?
                           ((TIMEOUT > CS_HOLD) ? TIMEOUT : CS_HOLD) :
                           ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
  localparam int CNTW    = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, SETUP, ISSUE, BUSY, HOLD, RESP} state_t;

  state_t            state, state_nxt;
  logic [CNTW-1:0]   cnt, cnt_nxt;
  logic              err_flag, err_nxt;
  logic [IDXW-1:0]   ptr;
  logic [IDXW-1:0]   pick;
  logic              pick_vld;
  logic              grant;

  logic [NREQ-1:0]   gnt_nxt, done_nxt;
  logic              done_err_nxt, busy_nxt, ser_valid_nxt, ser_n_cs_nxt;

`ifdef SER_RETRY_EN
  localparam int RTW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RTW-1:0]    retry_cnt;
`endif

  // Round-robin search: first set request starting just after the last
  // winner, wrapping modulo NREQ. The last winner itself is checked last.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = ptr;
    pick_vld = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!pick_vld && req[idx]) begin
        pick     = IDXW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  assign grant = (state == IDLE) && pick_vld;

  // State, shared phase counter, failure status and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      err_flag <= 1'b0;
      ptr      <= IDXW'(NREQ - 1);
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      err_flag <= err_nxt;
      if (grant) ptr <= pick;
    end
  end

`ifdef SER_RETRY_EN
  // Attempts already retried for the current payload; restarts at each grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt <= '0;
    end else if (grant) begin
      retry_cnt <= '0;
    end else if (state == HOLD && state_nxt == SETUP) begin
      retry_cnt <= retry_cnt + RTW'(1);
    end
  end
`endif

  // Next-state logic. Serializer errors take priority over completion and
  // timeout; the counter keeps running across ISSUE->BUSY so that the
  // timeout bounds the whole hand-off plus shift-out.
  always_comb begin
    state_nxt = state;
    err_nxt   = err_flag;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = SETUP;
          err_nxt   = 1'b0;
        end
      end
      SETUP: begin
        if (ser_err) begin
          state_nxt = HOLD;
          err_nxt   = 1'b1;
        end else if (cnt == CNTW'(CS_SETUP - 1)) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (ser_err || cnt == CNTW'(TIMEOUT - 1)) begin
          state_nxt = HOLD;
          err_nxt   = 1'b1;
        end else if (!ser_ready) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (ser_err) begin
          state_nxt = HOLD;
          err_nxt   = 1'b1;
        end else if (ser_ready) begin
          state_nxt = HOLD;
          err_nxt   = 1'b0;
        end else if (cnt == CNTW'(TIMEOUT - 1)) begin
          state_nxt = HOLD;
          err_nxt   = 1'b1;
        end
      end
      HOLD: begin
        if (cnt == CNTW'(CS_HOLD - 1)) begin
          state_nxt = RESP;
`ifdef SER_RETRY_EN
          if (err_flag && (retry_cnt < RTW'(MAX_RETRY))) begin
            state_nxt = SETUP;
            err_nxt   = 1'b0;
          end
`endif
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (state == IDLE ||
        (state_nxt != state && !(state == ISSUE && state_nxt == BUSY)))
      cnt_nxt = '0;
    else
      cnt_nxt = cnt + CNTW'(1);
  end

  // Output values for the coming cycle, derived from the state being
  // entered so every output comes straight from a flop.
  always_comb begin
    gnt_nxt  = '0;
    done_nxt = '0;
    if (grant) gnt_nxt[pick] = 1'b1;
    if (state_nxt == RESP) done_nxt[ptr] = 1'b1;
    done_err_nxt  = (state_nxt == RESP) && err_flag;
    busy_nxt      = (state_nxt != IDLE);
    ser_valid_nxt = (state_nxt == ISSUE);
    ser_n_cs_nxt  = !(state_nxt inside {SETUP, ISSUE, BUSY, HOLD});
  end

  // Registered outputs and the latched payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt        <= '0;
      done       <= '0;
      done_err   <= 1'b0;
      busy       <= 1'b0;
      ser_valid  <= 1'b0;
      ser_n_cs   <= 1'b1;
      ser_opcode <= '0;
      ser_addr   <= '0;
    end else begin
      gnt       <= gnt_nxt;
      done      <= done_nxt;
      done_err  <= done_err_nxt;
      busy      <= busy_nxt;
      ser_valid <= ser_valid_nxt;
      ser_n_cs  <= ser_n_cs_nxt;
      if (grant) begin
        ser_opcode <= req_opcode[int'(pick)*OPCODEW +: OPCODEW];
        ser_addr   <= req_addr[int'(pick)*ADDRW +: ADDRW];
      end
    end
  end

endmodule
